emu_retire_checker: RTL

- Sequences the RV_EMU emulation model against the CPU retire stream.
- Buffers emulator-predicted retire records in a FIFO and pops one per CPU retirement.
- On each pop, compares the fields enabled by that record's 15-bit CHECKS flag vector.
- Latches mismatch, underflow and retire-timeout errors for the formal/sim harness.

---
 rtl/emu_retire_checker.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/emu_retire_checker.sv
// rtl/emu_retire_checker.sv - emulator-vs-CPU retire record checker with predicted-record FIFO
// Build option: EMU_CHK_STICKY_EN (sticky errors, HALT state); default build pulses errors and keeps checking.
module emu_retire_checker #(
   parameter int DEPTH   = 4,
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 64
) (
   input  logic            clk_in,
   input  logic            reset_n_in,
   input  logic            emu_valid_in,
   output logic            emu_ready_out,
   input  logic [14:0]     emu_checks_in,
   input  logic [XLEN-1:0] emu_pc_in,
   input  logic            emu_gpr_wr_in,
   input  logic [4:0]      emu_gpr_addr_in,
   input  logic [XLEN-1:0] emu_gpr_data_in,
   input  logic [1:0]      emu_mode_in,
   input  logic            cpu_ret_valid_in,
   input  logic [XLEN-1:0] cpu_pc_in,
   input  logic            cpu_gpr_wr_in,
   input  logic [4:0]      cpu_gpr_addr_in,
   input  logic [XLEN-1:0] cpu_gpr_data_in,
   input  logic [1:0]      cpu_mode_in,
   output logic            mismatch_out,
   output logic [14:0]     mismatch_mask_out,
   output logic            underflow_out,
   output logic            timeout_out,
   output logic [XLEN-1:0] err_pc_out,
   output logic [31:0]     checked_cnt_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam int CHK_PC       = 14;
   localparam int CHK_GPR_WR   = 13;
   localparam int CHK_GPR_ADDR = 12;
   localparam int CHK_GPR_DATA = 11;
   localparam int CHK_MODE     = 0;

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_HALT} state_t;

   typedef struct packed {
      logic [14:0]     checks;
      logic [XLEN-1:0] pc;
      logic            gpr_wr;
      logic [4:0]      gpr_addr;
      logic [XLEN-1:0] gpr_data;
      logic [1:0]      mode;
   } rec_t;

   rec_t            fifo_mem_q [DEPTH];
   rec_t            emu_rec;
   rec_t            head;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            mismatch_q, mismatch_d;
   logic [14:0]     mask_q, mask_d;
   logic            underflow_q, underflow_d;
   logic            timeout_q, timeout_d;
   logic [XLEN-1:0] err_pc_q, err_pc_d;
   logic [31:0]     checked_q, checked_d;

   logic            halted;
   logic            push, pop;
   logic            underflow_now, timeout_now, mismatch_now;
   logic [14:0]     mask_now;
   logic            both_wr;

   always_comb begin
      emu_rec = '{checks: emu_checks_in, pc: emu_pc_in, gpr_wr: emu_gpr_wr_in,
                  gpr_addr: emu_gpr_addr_in, gpr_data: emu_gpr_data_in, mode: emu_mode_in};
   end

`ifdef EMU_CHK_STICKY_EN
   assign halted = (state_q == ST_HALT);
`else
   assign halted = 1'b0;
`endif

   // Ready comes only from registered state, so a full FIFO never accepts in a pop cycle.
   assign emu_ready_out = reset_n_in && (count_q < CW'(DEPTH)) && !halted;

   always_comb begin
      head          = fifo_mem_q[rd_ptr_q];
      push          = emu_valid_in && emu_ready_out;
      pop           = cpu_ret_valid_in && (count_q != '0) && !halted;
      underflow_now = cpu_ret_valid_in && (count_q == '0) && !halted;
      both_wr       = head.gpr_wr && cpu_gpr_wr_in;

      mask_now = '0;
      if (pop) begin
         mask_now[CHK_PC]       = head.checks[CHK_PC] && (head.pc != cpu_pc_in);
         mask_now[CHK_GPR_WR]   = head.checks[CHK_GPR_WR] && (head.gpr_wr != cpu_gpr_wr_in);
         mask_now[CHK_GPR_ADDR] = head.checks[CHK_GPR_ADDR] && both_wr
                                  && (head.gpr_addr != cpu_gpr_addr_in);
         mask_now[CHK_GPR_DATA] = head.checks[CHK_GPR_DATA] && both_wr
                                  && (head.gpr_addr != 5'd0)
                                  && (head.gpr_data != cpu_gpr_data_in);
         mask_now[CHK_MODE]     = head.checks[CHK_MODE] && (head.mode != cpu_mode_in);
      end
      mismatch_now = |mask_now;
      timeout_now  = (state_q == ST_ARMED) && !pop && (tmo_q == TW'(TIMEOUT - 1));
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q + AW'(push);
      rd_ptr_d  = rd_ptr_q + AW'(pop);
      count_d   = count_q + CW'(push) - CW'(pop);
      checked_d = checked_q + 32'(pop);
`ifndef EMU_CHK_STICKY_EN
      // A timeout flushes everything, including a record offered in the same cycle.
      if (timeout_now) begin
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end
`endif

      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (count_d != '0) state_d = ST_ARMED;
         ST_ARMED: if (count_d == '0) state_d = ST_IDLE;
         default:  state_d = state_q;
      endcase
`ifdef EMU_CHK_STICKY_EN
      if (mismatch_now || timeout_now || underflow_now) state_d = ST_HALT;
`endif

      tmo_d = '0;
      if ((state_q == ST_ARMED) && (state_d == ST_ARMED) && !pop) tmo_d = tmo_q + TW'(1);
   end

   always_comb begin
`ifdef EMU_CHK_STICKY_EN
      mismatch_d  = mismatch_q || mismatch_now;
      underflow_d = underflow_q || underflow_now;
      timeout_d   = timeout_q || timeout_now;
      mask_d      = mismatch_now ? mask_now : mask_q;
      err_pc_d    = err_pc_q;
`else
      mismatch_d  = mismatch_now;
      underflow_d = underflow_now;
      timeout_d   = timeout_now;
      mask_d      = mask_now;
      err_pc_d    = '0;
`endif
      if (mismatch_now)       err_pc_d = head.pc;
      else if (timeout_now)   err_pc_d = head.pc;
      else if (underflow_now) err_pc_d = '0;
   end

   always_ff @(posedge clk_in) begin
      if (push) fifo_mem_q[wr_ptr_q] <= emu_rec;
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         tmo_q       <= '0;
         mismatch_q  <= 1'b0;
         mask_q      <= '0;
         underflow_q <= 1'b0;
         timeout_q   <= 1'b0;
         err_pc_q    <= '0;
         checked_q   <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         tmo_q       <= tmo_d;
         mismatch_q  <= mismatch_d;
         mask_q      <= mask_d;
         underflow_q <= underflow_d;
         timeout_q   <= timeout_d;
         err_pc_q    <= err_pc_d;
         checked_q   <= checked_d;
      end
   end

   assign mismatch_out      = mismatch_q;
   assign mismatch_mask_out = mask_q;
   assign underflow_out     = underflow_q;
   assign timeout_out       = timeout_q;
   assign err_pc_out        = err_pc_q;
   assign checked_cnt_out   = checked_q;

endmodule
